spi_master_arbiter: RTL and testbench

- Round-robin arbiter/sequencer sharing one spi_master instance among NREQ requesters.
- Grants one requester at a time, issues its word to the master and waits for both tx and rx completion.
- Returns the received byte with a per-requester done pulse.
- Has a watchdog so a hung transfer cannot lock the bus.

---
 rtl/spi_master_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin sequencer sharing one spi_master among NREQ requesters.
// One transfer in flight at a time; a watchdog aborts transfers that never complete.
module spi_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 9,
    parameter int TIMEOUT = 64
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic [NREQ-1:0]         I_req,
    input  logic [NREQ*WIDTH-1:0]   I_req_data,
    output logic [NREQ-1:0]         O_gnt,
    output logic [NREQ-1:0]         O_done,
    output logic [7:0]              O_rx_data,
    output logic                    O_timeout,
    output logic                    O_busy,
    output logic                    O_spi_en,
    output logic [WIDTH-1:0]        O_spi_data,
    input  logic                    I_spi_tx_done,
    input  logic                    I_spi_rx_done,
    input  logic [7:0]              I_spi_rx_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NREQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             spi_en_q, spi_en_d;
    logic [WIDTH-1:0] spi_data_q, spi_data_d;
    logic             tx_seen_q, tx_seen_d;
    logic             rx_seen_q, rx_seen_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Unpack the flattened request words into an indexable array.
    logic [WIDTH-1:0] slot [NREQ];
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign slot[gi] = I_req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate requests so that offset 0 is the current pointer, then take the lowest set bit.
    logic [2*NREQ-1:0] req2;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     off;
    logic [IW:0]       sum;
    logic [IW-1:0]     pick;
    logic [NREQ-1:0]   pick_oh;
    logic [IW:0]       inc;
    logic [IW-1:0]     ptr_after;

    assign req2 = {I_req, I_req};
    assign rot  = req2[ptr_q +: NREQ];

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i[IW-1:0];
            end
        end
    end

    assign sum  = {1'b0, ptr_q} + {1'b0, off};
    assign pick = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : sum[IW-1:0];

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    assign inc       = {1'b0, sel_q} + (IW + 1)'(1);
    assign ptr_after = (inc >= NREQ_W) ? '0 : inc[IW-1:0];

    logic complete;
    assign complete = (tx_seen_q | I_spi_tx_done) & (rx_seen_q | I_spi_rx_done);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        done_d     = done_q;
        rx_data_d  = rx_data_q;
        timeout_d  = timeout_q;
        busy_d     = busy_q;
        spi_en_d   = spi_en_q;
        spi_data_d = spi_data_q;
        tx_seen_d  = tx_seen_q;
        rx_seen_d  = rx_seen_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|I_req) begin
                    state_d    = ST_ISSUE;
                    sel_d      = pick;
                    gnt_d      = pick_oh;
                    spi_data_d = slot[pick];
                    spi_en_d   = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                spi_en_d  = 1'b0;
                tx_seen_d = 1'b0;
                rx_seen_d = 1'b0;
                cnt_d     = '0;
            end
            ST_WAIT: begin
                tx_seen_d = tx_seen_q | I_spi_tx_done;
                rx_seen_d = rx_seen_q | I_spi_rx_done;
                if (I_spi_rx_done) begin
                    rx_data_d = I_spi_rx_data;
                end
                // Completion takes priority over a coincident watchdog expiry.
                if (complete) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = gnt_q;
                    timeout_d = 1'b1;
                    rx_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                done_d    = '0;
                timeout_d = 1'b0;
                gnt_d     = '0;
                busy_d    = 1'b0;
                ptr_d     = ptr_after;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rx_data_q  <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            spi_en_q   <= 1'b0;
            spi_data_q <= '0;
            tx_seen_q  <= 1'b0;
            rx_seen_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            spi_en_q   <= spi_en_d;
            spi_data_q <= spi_data_d;
            tx_seen_q  <= tx_seen_d;
            rx_seen_q  <= rx_seen_d;
            cnt_q      <= cnt_d;
        end
    end

    assign O_gnt      = gnt_q;
    assign O_done     = done_q;
    assign O_rx_data  = rx_data_q;
    assign O_timeout  = timeout_q;
    assign O_busy     = busy_q;
    assign O_spi_en   = spi_en_q;
    assign O_spi_data = spi_data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: arbitration order, completion ordering,
// watchdog abort, mid-transfer reset and request drop.
module tb_spi_master_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 9;
    localparam int TIMEOUT = 64;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [7:0]            rx_data;
    logic                  timeout;
    logic                  busy;
    logic                  spi_en;
    logic [WIDTH-1:0]      spi_data;
    logic                  spi_tx_done;
    logic                  spi_rx_done;
    logic [7:0]            spi_rx_data;

    spi_master_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_req         (req),
        .I_req_data    (req_data),
        .O_gnt         (gnt),
        .O_done        (done),
        .O_rx_data     (rx_data),
        .O_timeout     (timeout),
        .O_busy        (busy),
        .O_spi_en      (spi_en),
        .O_spi_data    (spi_data),
        .I_spi_tx_done (spi_tx_done),
        .I_spi_rx_done (spi_rx_done),
        .I_spi_rx_data (spi_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transfer starting from IDLE with requests already driven.
    // tx_c/rx_c: sample index (after issue) at which each master pulse is driven.
    task automatic xfer(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d,
                        input int tx_c, input int rx_c, input logic [7:0] rxb,
                        input int drop_c);
        logic [NREQ*WIDTH-1:0] saved;
        int last;
        last = (tx_c > rx_c) ? tx_c : rx_c;
        tick;
        check("issue_gnt", gnt, g);
        check("issue_en", spi_en, 1);
        check("issue_data", spi_data, d);
        check("issue_busy", busy, 1);
        check("issue_done", done, 0);
        saved = req_data;
        for (int c = 1; c <= last; c++) begin
            tick;
            check("wait_en", spi_en, 0);
            check("wait_done", done, 0);
            check("wait_gnt", gnt, g);
            if (c == 1) req_data = ~saved;
            if (c == drop_c) req = req & ~g;
            spi_tx_done = (c == tx_c);
            spi_rx_done = (c == rx_c);
            spi_rx_data = (c == rx_c) ? rxb : 8'hEE;
        end
        tick;
        spi_tx_done = 1'b0;
        spi_rx_done = 1'b0;
        spi_rx_data = 8'h00;
        req_data    = saved;
        check("done_pulse", done, g);
        check("done_gnt", gnt, g);
        check("done_rx", rx_data, rxb);
        check("done_tmo", timeout, 0);
        check("done_data", spi_data, d);
        tick;
        check("idle_done", done, 0);
        check("idle_gnt", gnt, 0);
        check("idle_busy", busy, 0);
        check("idle_en", spi_en, 0);
        $display("xfer gnt=%b data=%h rx=%h", g, d, rxb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0;
        spi_tx_done = 1'b0; spi_rx_done = 1'b0; spi_rx_data = 8'h00;
        tick; tick;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        check("rst_tmo", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_en", spi_en, 0);
        check("rst_data", spi_data, 0);
        rst = 1'b0;
        tick;

        // Round robin with all requests held: 0,1,2,3,0.
        req_data = {9'h133, 9'h122, 9'h111, 9'h100};
        req = 4'b1111;
        xfer(4'b0001, 9'h100, 2, 3, 8'hA0, 0);
        xfer(4'b0010, 9'h111, 3, 2, 8'hA1, 0);
        xfer(4'b0100, 9'h122, 1, 1, 8'hA2, 0);
        xfer(4'b1000, 9'h133, 4, 2, 8'hA3, 0);
        xfer(4'b0001, 9'h100, 2, 2, 8'hA4, 0);
        req = '0;

        // Single requester.
        req_data = {9'h000, 9'h1A5, 9'h0FF, 9'h000};
        req = 4'b0100;
        xfer(4'b0100, 9'h1A5, 20, 22, 8'h3C, 0);
        req = '0;

        // Stray pulses in IDLE must not touch the received byte.
        tick;
        spi_tx_done = 1'b1; spi_rx_done = 1'b1; spi_rx_data = 8'h55;
        tick;
        spi_tx_done = 1'b0; spi_rx_done = 1'b0; spi_rx_data = 8'h00;
        tick;
        check("stray_rx", rx_data, 8'h3C);
        check("stray_busy", busy, 0);
        check("stray_done", done, 0);

        // rx before tx, then both coincident; requester 3 re-requests right away.
        req_data = {9'h0C3, 9'h000, 9'h000, 9'h000};
        req = 4'b1000;
        xfer(4'b1000, 9'h0C3, 6, 3, 8'h5A, 0);
        xfer(4'b1000, 9'h0C3, 4, 4, 8'h69, 0);
        req = '0;

        // Watchdog abort, then the next requester is served.
        req_data = {9'h000, 9'h000, 9'h022, 9'h011};
        req = 4'b0011;
        tick;
        check("tmo_gnt", gnt, 4'b0001);
        check("tmo_en", spi_en, 1);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick;
            check("tmo_wait_done", done, 0);
            check("tmo_wait_flag", timeout, 0);
        end
        tick;
        check("tmo_done", done, 4'b0001);
        check("tmo_flag", timeout, 1);
        check("tmo_rx", rx_data, 0);
        tick;
        check("tmo_idle_done", done, 0);
        check("tmo_idle_flag", timeout, 0);
        check("tmo_idle_busy", busy, 0);
        $display("xfer gnt=0001 data=011 aborted");
        xfer(4'b0010, 9'h022, 2, 3, 8'h7E, 0);
        req = '0;

        // Requester 1 drops its request two cycles after grant.
        req = 4'b0010;
        xfer(4'b0010, 9'h022, 5, 6, 8'h81, 2);
        check("drop_req", req, 0);

        // Reset five cycles after issue.
        req_data = {9'h000, 9'h1A5, 9'h000, 9'h011};
        req = 4'b0100;
        tick;
        check("rstw_gnt", gnt, 4'b0100);
        check("rstw_en", spi_en, 1);
        for (int c = 1; c <= 5; c++) tick;
        rst = 1'b1;
        req = '0;
        tick;
        rst = 1'b0;
        check("rstw_gnt0", gnt, 0);
        check("rstw_busy", busy, 0);
        check("rstw_done", done, 0);
        check("rstw_en0", spi_en, 0);
        for (int c = 1; c <= 3; c++) begin
            spi_tx_done = 1'b1; spi_rx_done = 1'b1;
            tick;
            check("rstw_after_done", done, 0);
        end
        spi_tx_done = 1'b0; spi_rx_done = 1'b0;
        $display("xfer gnt=0100 data=1a5 reset");
        req = 4'b0001;
        xfer(4'b0001, 9'h011, 3, 3, 8'hC5, 0);
        req = '0;

        // Pointer now 1: requesters 0 and 3 pending -> 3 wins.
        req_data = {9'h1E3, 9'h000, 9'h000, 9'h011};
        req = 4'b1001;
        xfer(4'b1000, 9'h1E3, 1, 2, 8'h96, 0);
        req = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
